// File: rtl/game_pkg.sv
// Shared encodings for the obstacle game: FSM states, scheduler phases, counter width.
package game_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    S_MAIN     = 2'b00,
    S_CONTINUE = 2'b01,
    S_OVER     = 2'b10,
    S_CLEAR    = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    P_IDLE   = 2'b00,
    P_COUNT  = 2'b01,
    P_RUN    = 2'b10,
    P_FREEZE = 2'b11
  } phase_e;

endpackage

// File: rtl/tick_divider.sv
// Free-running divider with a period latched on clear and on every wrap.
module tick_divider
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             wrap_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             tick_q, tick_d;

  // The wrap is a combinational early warning so the parent can register companions of the tick.
  assign wrap_o = en_i && (cnt_q == period_q - CNT_W'(1));
  assign tick_o = tick_q;

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    tick_d   = 1'b0;
    if (clr_i) begin
      cnt_d    = '0;
      period_d = period_i;
    end else if (en_i) begin
      if (wrap_o) begin
        cnt_d    = '0;
        period_d = period_i;
        tick_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      tick_q   <= tick_d;
    end
  end

endmodule

// File: rtl/game_scheduler.sv
// Pacing controller: countdown, scroll tick and spawn pacing, score/level keeping, clear flag.
module game_scheduler
  import game_pkg::*;
#(
  parameter int TICK_BASE      = 400,
  parameter int TICK_STEP      = 100,
  parameter int COUNTDOWN_MS   = 3000,
  parameter int LEVEL_UP_SCORE = 10,
  parameter int CLEAR_SCORE    = 40,
  parameter int SPAWN_EVERY    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] game_state,
  input  logic       obstacle_passed,
  output logic       countdown_active,
  output logic [1:0] countdown_sec,
  output logic       scroll_tick,
  output logic       spawn_req,
  output logic [7:0] score,
  output logic [1:0] level,
  output logic       game_clear
);

  localparam int CW3 = CNT_W + 3;
  localparam logic [CNT_W-1:0] PER0       = CNT_W'(TICK_BASE);
  localparam logic [CNT_W-1:0] PER1       = CNT_W'(TICK_BASE - TICK_STEP);
  localparam logic [CNT_W-1:0] PER2       = CNT_W'(TICK_BASE - 2 * TICK_STEP);
  localparam logic [CNT_W-1:0] PER3       = CNT_W'(TICK_BASE - 3 * TICK_STEP);
  localparam logic [CNT_W-1:0] CD_LOAD    = CNT_W'(COUNTDOWN_MS - 1);
  localparam logic [CW3-1:0]   THR1       = CW3'(COUNTDOWN_MS);
  localparam logic [CW3-1:0]   THR2       = CW3'(2 * COUNTDOWN_MS);
  localparam logic [CNT_W-1:0] LVL_LAST   = CNT_W'(LEVEL_UP_SCORE - 1);
  localparam logic [CNT_W-1:0] SPAWN_LAST = CNT_W'(SPAWN_EVERY - 1);
  localparam logic [7:0]       CLEAR_TH   = 8'(CLEAR_SCORE);

  // ceil(3*(cnt+1)/COUNTDOWN_MS) by comparing against the one- and two-third marks.
  function automatic logic [1:0] secs_left(input logic [CNT_W-1:0] cnt);
    logic [CW3-1:0] rem3;
    rem3 = (CW3'(cnt) << 1) + CW3'(cnt) + CW3'(3);
    if (rem3 > THR2)      return 2'd3;
    else if (rem3 > THR1) return 2'd2;
    else                  return 2'd1;
  endfunction

  function automatic logic [CNT_W-1:0] period_for(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return PER0;
      2'd1:    return PER1;
      2'd2:    return PER2;
      default: return PER3;
    endcase
  endfunction

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cd_q, cd_d;
  logic [CNT_W-1:0] spawn_cnt_q, spawn_cnt_d;
  logic [CNT_W-1:0] lvl_cnt_q, lvl_cnt_d;
  logic [7:0]       score_q, score_d;
  logic [1:0]       level_q, level_d;
  logic             clear_q, clear_d;
  logic             cd_active_q, cd_active_d;
  logic [1:0]       cd_sec_q, cd_sec_d;
  logic             spawn_req_q, spawn_req_d;
  logic             run_go, div_clr, div_wrap, div_tick;
  logic             halt_req;

  assign halt_req = (game_state == S_OVER) || (game_state == S_CLEAR);

  always_comb begin
    phase_d = phase_q;
    cd_d    = cd_q;
    case (phase_q)
      P_IDLE: begin
        if (game_state == S_CONTINUE) begin
          phase_d = P_COUNT;
          cd_d    = CD_LOAD;
        end
      end
      P_COUNT: begin
        if (halt_req)           phase_d = P_FREEZE;
        else if (cd_q == '0)    phase_d = P_RUN;
        else                    cd_d    = cd_q - CNT_W'(1);
      end
      P_RUN: begin
        if (halt_req) phase_d = P_FREEZE;
      end
      default: ;
    endcase
    if (game_state == S_MAIN) begin
      phase_d = P_IDLE;
      cd_d    = '0;
    end
  end

  // Staying in P_RUN implies game_state is CONTINUE, so halts and MAIN both stop counting.
  assign run_go  = (phase_q == P_RUN) && (phase_d == P_RUN);
  assign div_clr = (phase_d == P_IDLE) || (phase_q == P_IDLE) || (phase_q == P_COUNT);

  tick_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (div_clr),
    .en_i     (run_go),
    .period_i (period_for(level_q)),
    .wrap_o   (div_wrap),
    .tick_o   (div_tick)
  );

  always_comb begin
    spawn_cnt_d = spawn_cnt_q;
    spawn_req_d = 1'b0;
    score_d     = score_q;
    level_d     = level_q;
    lvl_cnt_d   = lvl_cnt_q;
    clear_d     = clear_q;
    if (div_clr) begin
      spawn_cnt_d = '0;
    end else if (div_wrap) begin
      if (spawn_cnt_q == SPAWN_LAST) begin
        spawn_cnt_d = '0;
        spawn_req_d = 1'b1;
      end else begin
        spawn_cnt_d = spawn_cnt_q + CNT_W'(1);
      end
    end
    if (run_go && obstacle_passed) begin
      if (score_q != 8'hFF) score_d = score_q + 8'd1;
      if (level_q != 2'd3) begin
        if (lvl_cnt_q == LVL_LAST) begin
          lvl_cnt_d = '0;
          level_d   = level_q + 2'd1;
        end else begin
          lvl_cnt_d = lvl_cnt_q + CNT_W'(1);
        end
      end
    end
    if ((phase_q == P_RUN) && (score_q >= CLEAR_TH)) clear_d = 1'b1;
    if (phase_d == P_IDLE) begin
      score_d   = '0;
      level_d   = '0;
      lvl_cnt_d = '0;
      clear_d   = 1'b0;
    end
    cd_active_d = (phase_d == P_COUNT);
    cd_sec_d    = cd_active_d ? secs_left(cd_d) : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= P_IDLE;
      cd_q        <= '0;
      spawn_cnt_q <= '0;
      lvl_cnt_q   <= '0;
      score_q     <= '0;
      level_q     <= '0;
      clear_q     <= 1'b0;
      cd_active_q <= 1'b0;
      cd_sec_q    <= '0;
      spawn_req_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cd_q        <= cd_d;
      spawn_cnt_q <= spawn_cnt_d;
      lvl_cnt_q   <= lvl_cnt_d;
      score_q     <= score_d;
      level_q     <= level_d;
      clear_q     <= clear_d;
      cd_active_q <= cd_active_d;
      cd_sec_q    <= cd_sec_d;
      spawn_req_q <= spawn_req_d;
    end
  end

  assign countdown_active = cd_active_q;
  assign countdown_sec    = cd_sec_q;
  assign scroll_tick      = div_tick;
  assign spawn_req        = spawn_req_q;
  assign score            = score_q;
  assign level            = level_q;
  assign game_clear       = clear_q;

endmodule

// File: tb/tb_game_scheduler.sv
// Bench for game_scheduler: directed scenarios plus random play against a behavioural model.
module tb_game_scheduler;

  localparam int TB = 8, TS = 2, CD = 6, LU = 2, CS = 5, SE = 2;

  logic       clk = 1'b0;
  logic       rst, op;
  logic [1:0] gs;
  logic       cd_act, tick, spawn, gclr;
  logic [1:0] cd_sec, lvl;
  logic [7:0] score;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  game_scheduler #(
    .TICK_BASE(TB), .TICK_STEP(TS), .COUNTDOWN_MS(CD),
    .LEVEL_UP_SCORE(LU), .CLEAR_SCORE(CS), .SPAWN_EVERY(SE)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .game_state       (gs),
    .obstacle_passed  (op),
    .countdown_active (cd_act),
    .countdown_sec    (cd_sec),
    .scroll_tick      (tick),
    .spawn_req        (spawn),
    .score            (score),
    .level            (lvl),
    .game_clear       (gclr)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 countdown, 2 running, 3 frozen.
  int m_ph, m_rem, m_el, m_per, m_ticks, m_score, m_pil, m_lvl, m_clr, m_tick, m_spawn;

  always @(posedge clk) begin
    m_tick  = 0;
    m_spawn = 0;
    if (rst || gs == 2'd0) begin
      m_ph = 0; m_rem = 0; m_el = 0; m_per = 0; m_ticks = 0;
      m_score = 0; m_pil = 0; m_lvl = 0; m_clr = 0;
    end else begin
      case (m_ph)
        0: if (gs == 2'd1) begin m_ph = 1; m_rem = CD; end
        1: begin
          if (gs >= 2'd2) m_ph = 3;
          else if (m_rem == 1) begin m_ph = 2; m_el = 0; m_per = TB; m_ticks = 0; end
          else m_rem--;
        end
        2: begin
          if (m_score >= CS) m_clr = 1;
          if (gs >= 2'd2) m_ph = 3;
          else begin
            m_el++;
            if (m_el == m_per) begin
              m_el = 0;
              m_tick = 1;
              m_ticks++;
              m_spawn = (m_ticks % SE == 0);
              m_per = TB - m_lvl * TS;
            end
            if (op) begin
              if (m_score < 255) m_score++;
              if (m_lvl < 3) begin
                m_pil++;
                if (m_pil == LU) begin m_pil = 0; m_lvl++; end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic [15:0] got_v, exp_v;
  int es;
  always @(negedge clk) begin
    if (cmp_en) begin
      es = (m_ph == 1) ? (m_rem * 3 + CD - 1) / CD : 0;
      got_v = {cd_act, cd_sec, tick, spawn, score, lvl, gclr};
      exp_v = {(m_ph == 1), 2'(es), m_tick[0], m_spawn[0], 8'(m_score), 2'(m_lvl), m_clr[0]};
      check("model", int'(got_v), int'(exp_v));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input int limit, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tick && k < limit);
  endtask

  int k, len, nz, nt, r;
  logic [11:0] seq;

  initial begin
    rst = 1'b1; gs = 2'd0; op = 1'b0;
    cyc(2);
    cmp_en = 1'b1;
    check("reset_outputs", int'({cd_act, cd_sec, tick, spawn, score, lvl, gclr}), 0);
    rst = 1'b0;

    // Idle with MAIN
    nz = 0;
    repeat (20) begin
      cyc(1);
      if (cd_act || tick || spawn || gclr || cd_sec != 0 || score != 0 || lvl != 0) nz++;
    end
    check("idle_quiet", nz, 0);

    // Countdown and first ticks
    gs = 2'd1;
    cyc(1);
    len = 0; seq = '0;
    while (cd_act && len < 20) begin
      seq = {seq[9:0], cd_sec};
      len++;
      cyc(1);
    end
    check("cd_len", len, 6);
    check("cd_seq", int'(seq), 12'hFA5);
    wait_tick(40, k);
    check("first_tick_delay", k, 8);
    check("first_spawn", int'(spawn), 0);
    wait_tick(40, k);
    check("second_tick_period", k, 8);
    check("second_spawn", int'(spawn), 1);

    // Level up and period change
    op = 1'b1; cyc(1); op = 1'b0; cyc(1); op = 1'b1; cyc(1); op = 1'b0;
    check("score_two", int'(score), 2);
    check("level_one", int'(lvl), 1);
    wait_tick(40, k);
    check("old_period_rest", k, 5);
    wait_tick(40, k);
    check("new_period", k, 6);
    for (int i = 1; i <= 6; i++) begin
      op = (i == 1 || i == 6);
      cyc(1);
    end
    op = 1'b0;
    check("coinc_tick", int'(tick), 1);
    check("coinc_score", int'(score), 4);
    check("coinc_level", int'(lvl), 2);
    wait_tick(40, k);
    check("coinc_old_period", k, 6);
    wait_tick(40, k);
    check("level2_period", k, 4);

    // Clear, freeze, back to main
    op = 1'b1; cyc(1); op = 1'b0;
    check("score_five", int'(score), 5);
    check("clear_not_yet", int'(gclr), 0);
    cyc(1);
    check("clear_set", int'(gclr), 1);
    gs = 2'd3;
    nt = 0;
    repeat (20) begin cyc(1); nt += int'(tick) + int'(spawn); end
    check("freeze_no_ticks", nt, 0);
    check("freeze_score", int'(score), 5);
    check("freeze_clear", int'(gclr), 1);
    gs = 2'd1; cyc(3);
    check("freeze_ignores_continue", int'(cd_act), 0);
    gs = 2'd0; cyc(1);
    check("main_clears", int'({score, lvl, gclr}), 0);

    // Over with a simultaneous pass
    gs = 2'd1;
    wait_tick(40, k);
    check("restart_first_tick", k, 15);
    op = 1'b1; cyc(1); op = 1'b0; cyc(2);
    gs = 2'd2; op = 1'b1; cyc(1); op = 1'b0;
    check("over_ignores_pass", int'(score), 1);
    nt = 0;
    repeat (30) begin cyc(1); nt += int'(tick) + int'(spawn); end
    check("over_no_ticks", nt, 0);
    gs = 2'd0; cyc(1);

    // Reset mid-countdown
    gs = 2'd1; cyc(3);
    check("cd_before_rst", int'(cd_act), 1);
    rst = 1'b1; cyc(1);
    check("rst_clears", int'({cd_act, cd_sec, tick, spawn, score, lvl, gclr}), 0);
    rst = 1'b0; cyc(1);
    check("cd_restart", int'({cd_act, cd_sec}), 3'b111);
    len = 0;
    while (cd_act && len < 20) begin len++; cyc(1); end
    check("cd_restart_len", len, 6);

    // Random play
    repeat (4000) begin
      r = $urandom_range(0, 99);
      if (r < 1) gs = 2'($urandom_range(0, 3));
      else if (r < 2) gs = 2'd1;
      op  = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0; op = 1'b0; gs = 2'd0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
